// File: rtl/booth_mult32_seq.sv
// booth_mult32_seq
// ----------------
// Sequential signed multiplier built on radix-4 Booth (bit-pair) recoding.
// A start pulse in IDLE captures both operands. Each following clock retires
// one bit-pair of the multiplier. After WIDTH/2 steps the 2*WIDTH-bit product
// is written to product_hi/product_lo, and done pulses for one cycle.
//
// Handshake: start is sampled only while busy=0. The cycle that has done=1 is
// already IDLE, so a start in that cycle is accepted. Results hold until the
// next completed operation or reset.
//
// Ports:
//   clk           system clock, rising edge
//   clr           asynchronous active-low reset
//   start         request pulse, ignored while busy
//   multiplicand  signed operand M (WIDTH bits)
//   multiplier    signed operand Q (WIDTH bits)
//   busy          high while an operation is in progress
//   done          one-cycle pulse when the product outputs are valid
//   product_hi    upper WIDTH bits of the signed product
//   product_lo    lower WIDTH bits of the signed product
//   dbg_state     current FSM state (0 = IDLE, 1 = BUSY)
//
// Optional feature (macro MUL_EARLY_TERM_EN):
//   When defined, a BUSY edge can find that every unconsumed multiplier bit
//   and q_-1 are identical. In that case all remaining recodings are zero, so
//   that edge finishes the operation with a single wide arithmetic shift.
//   Latency then ranges from 1 to WIDTH/2 cycles. When the macro is undefined,
//   latency is fixed at WIDTH/2 cycles.

module booth_mult32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic [0:0]       dbg_state
);

  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH+1:0] a_reg;   // two guard bits absorb -2M of the most-negative M
  logic [WIDTH-1:0] q_reg;
  logic             q_m1;
  logic [CW-1:0]    cnt;

  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] m2_ext;
  logic [WIDTH+1:0] addend;
  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] a_next;
  logic [WIDTH-1:0] q_next;
  logic             last_step;

  assign dbg_state = state;
  assign m_ext     = {{2{m_reg[WIDTH-1]}}, m_reg};
  assign m2_ext    = {m_ext[WIDTH:0], 1'b0};

  // Recode {Q[1],Q[0],q_-1} into one of {0, +M, +2M, -2M, -M}.
  always_comb begin
    addend = '0;
    case ({q_reg[1:0], q_m1})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m2_ext;
      3'b100:         addend = -m2_ext;
      3'b101, 3'b110: addend = -m_ext;
      default:        addend = '0;
    endcase
  end

  // Add modulo 2^(WIDTH+2), then shift {A,Q,q_-1} right arithmetically by 2.
  assign sum       = a_reg + addend;
  assign a_next    = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
  assign q_next    = {sum[1:0], q_reg[WIDTH-1:2]};
  assign last_step = (cnt == CW'(N - 1));

`ifdef MUL_EARLY_TERM_EN
  logic [WIDTH-1:0]           live;    // multiplier bits not yet consumed
  logic                       early;
  logic [CW:0]                sh_amt;
  logic signed [2*WIDTH+1:0]  aq_cat;
  logic signed [2*WIDTH+1:0]  aq_sh;

  // After cnt steps, the unconsumed multiplier bits sit in Q[WIDTH-1-2*cnt:0].
  always_comb begin
    live = '0;
    for (int i = 0; i < WIDTH; i++) begin
      live[i] = (i < (WIDTH - 2 * int'(cnt)));
    end
  end

  assign early  = ((&(q_reg | ~live)) & q_m1) | ((~|(q_reg & live)) & ~q_m1);
  assign sh_amt = (CW + 1)'(2 * (N - int'(cnt)));
  assign aq_cat = {a_reg, q_reg};
  assign aq_sh  = aq_cat >>> sh_amt;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      m_reg      <= '0;
      a_reg      <= '0;
      q_reg      <= '0;
      q_m1       <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            a_reg <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
`ifdef MUL_EARLY_TERM_EN
          if (early) begin
            product_hi <= aq_sh[2*WIDTH-1:WIDTH];
            product_lo <= aq_sh[WIDTH-1:0];
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end else
`endif
          begin
            a_reg <= a_next;
            q_reg <= q_next;
            q_m1  <= q_reg[1];
            cnt   <= cnt + CW'(1);
            if (last_step) begin
              product_hi <= a_next[WIDTH-1:0];
              product_lo <= q_next;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult32_seq.sv
// Directed bench for booth_mult32_seq (WIDTH = 32).
// Expected products are hand-computed constants. Expected latency is WIDTH/2,
// or, when MUL_EARLY_TERM_EN is defined, the first step at which the remaining
// multiplier bits and q_-1 agree.

module tb_booth_mult32_seq;

  logic        clk;
  logic        clr;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product_hi;
  logic [31:0] product_lo;
  logic [0:0]  dbg_state;

  int n_checks;
  int n_fail;

  booth_mult32_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product_hi   (product_hi),
    .product_lo   (product_lo),
    .dbg_state    (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected latency, in edges after the start edge
  function automatic int exp_lat(input logic [31:0] q);
`ifdef MUL_EARLY_TERM_EN
    for (int c = 0; c < 16; c++) begin
      logic rb;
      bit   uni;
      rb  = (c == 0) ? 1'b0 : q[2*c-1];
      uni = 1'b1;
      for (int i = 2 * c; i < 32; i++) if (q[i] != rb) uni = 1'b0;
      if (uni) return c + 1;
    end
    return 16;
`else
    return 16 + 0 * int'(q[0]);
`endif
  endfunction

  // Driver tasks. Each is entered and left 1ns after a rising edge.
  task automatic pulse_start(input logic [31:0] m, input logic [31:0] q);
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    forever begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (lat >= 40) begin
        check("done_timeout", {63'b0, done}, 64'd1);
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                        input logic [63:0] exp_prod);
    int lat, bc;
    pulse_start(m, q);
    check({tag, "_busy_after_start"}, {63'b0, busy}, 64'd1);
    check({tag, "_state_busy"}, {63'b0, dbg_state}, 64'd1);
    multiplicand = ~m;              // operand changes after start are ignored
    multiplier   = ~q;
    wait_done(lat, bc);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat(q)));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_lat(q)));
    check({tag, "_busy_at_done"}, {63'b0, busy}, 64'd0);
    check({tag, "_product"}, {product_hi, product_lo}, exp_prod);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, {63'b0, done}, 64'd0);
    check({tag, "_product_hold"}, {product_hi, product_lo}, exp_prod);
  endtask

  // Directed stimulus and scoreboard
  initial begin
    int lat, bc, dcnt, pre;
    n_checks     = 0;
    n_fail       = 0;
    clr          = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_product", {product_hi, product_lo}, 64'd0);
    check("reset_state", {63'b0, dbg_state}, 64'd0);
    clr = 1'b1;
    @(posedge clk); #1;

    run_op("m7_qm3",     32'd7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("minneg_sq",  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("maxpos_sq",  32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
    run_op("m1_sq",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    run_op("minneg_x1",  32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000);
    run_op("minneg_max", 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
    run_op("m6_qm1",     32'd6,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("m5_q0",      32'd5,         32'd0,         64'd0);

    // Start while busy is ignored. Start in the done cycle is accepted.
    pulse_start(32'd5, 32'd3);
    @(posedge clk); #1;
    start        = 1'b1;
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    @(posedge clk); #1;
    start        = 1'b0;
    multiplicand = 32'h1234_5678;
    multiplier   = 32'h0BAD_F00D;
    check("ignored_start_no_done", {63'b0, done}, 64'd0);
    wait_done(lat, bc);
    check("ignored_start_latency", 64'(lat + 2), 64'(exp_lat(32'd3)));
    check("ignored_start_product", {product_hi, product_lo}, 64'd15);
    pulse_start(32'd2, 32'hFFFF_FFFC);
    check("done_cycle_start_busy", {63'b0, busy}, 64'd1);
    wait_done(lat, bc);
    check("done_cycle_start_latency", 64'(lat), 64'(exp_lat(32'hFFFF_FFFC)));
    check("done_cycle_start_product", {product_hi, product_lo}, 64'hFFFF_FFFF_FFFF_FFF8);

    // Asynchronous abort mid-operation
    pre = exp_lat(32'd456) - 2;
    if (pre > 7) pre = 7;
    pulse_start(32'd123, 32'd456);
    repeat (pre) begin
      @(posedge clk); #1;
    end
    check("abort_busy_before", {63'b0, busy}, 64'd1);
    #2 clr = 1'b0;
    #1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_product", {product_hi, product_lo}, 64'd0);
    check("abort_state", {63'b0, dbg_state}, 64'd0);
    #3 clr = 1'b1;
    dcnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);
    check("abort_stays_idle", {63'b0, busy}, 64'd0);

    // Normal operation after the abort
    run_op("post_abort", 32'd123, 32'd456, 64'd56088);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mult32_seq.md
Name: booth_mult32_seq

Overview:
- Sequential signed multiplier using radix-4 Booth (bit-pair) recoding, the multiplicative counterpart of the combinational divider in the ALU.
- Produces a 2*WIDTH-bit product split into hi/lo halves for the HI/LO registers.
- Operands are captured on a start pulse; one bit-pair is retired per clock; a done pulse signals the result.
- The CPU control unit stalls on busy.

Parameters:
WIDTH, 32, operand width; must be even and >= 4.

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only when not busy
multiplicand  input  WIDTH  signed operand M
multiplier  input  WIDTH  signed operand Q
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when product_hi/product_lo are valid
product_hi  output  WIDTH  upper half of the signed product
product_lo  output  WIDTH  lower half of the signed product

Behaviour:
- Interface: one clock (clk); reset clr is asynchronous and active-low.
- Reset (clr=0) values:
  - busy=0, done=0, product_hi=0, product_lo=0.
  - Internal state IDLE, step counter 0, datapath registers 0.
- States:
  - IDLE: start=1 at an edge latches M and Q, sets A=0 and q_-1=0, sets busy=1, goes to BUSY.
  - BUSY: each edge performs one Booth step and increments the counter. The edge that completes step N=WIDTH/2 writes the product, drops busy, pulses done, and returns to IDLE.
- Booth step:
  - Selects D from {Q[1],Q[0],q_-1}: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - A is WIDTH+2 bits, sign-extended; the add is modulo 2^(WIDTH+2).
  - Then {A,Q,q_-1} arithmetic-shifts right by 2.
- Result: product = {A[WIDTH-1:0], Q}; product_hi = A[WIDTH-1:0], product_lo = Q.
- Latency: done is high in the cycle N edges after the start edge. For WIDTH=32, done asserts 16 cycles after start, and busy is high for exactly 16 cycles.
- Products hold their value until the next completed operation or reset. done is a single-cycle pulse.
- Boundary conditions:
  - start while busy: ignored; operands are not re-latched.
  - start in the same cycle done is asserted: accepted, since the state is already IDLE.
  - Operand changes after the start edge have no effect.
  - Most-negative operands (e.g. 0x80000000) need no special case; the 2-bit guard in A absorbs -2M.
  - clr asserted mid-operation: immediate abort to reset values; no done pulse.

Optional Feature:
Macro: MUL_EARLY_TERM_EN
- Defined:
  - At each BUSY edge, before stepping, checks whether all unconsumed multiplier bits and q_-1 are identical.
  - If they are, all remaining recodings are 0. That edge instead arithmetic-shifts {A,Q} right by 2*(steps remaining), writes the product, and pulses done.
  - Latency therefore ranges from 1 to N cycles, and the product is identical to the full run.
- Undefined: fixed latency of N cycles; no comparison logic is built.

Test Plan:
- M=7, Q=-3, start pulse -> done after 16 cycles; product_hi=0xFFFFFFFF, product_lo=0xFFFFFFEB; busy high for exactly 16 cycles.
- M=0x80000000, Q=0x80000000 -> product_hi=0x40000000, product_lo=0x00000000.
- M=0x7FFFFFFF, Q=0x7FFFFFFF -> product_hi=0x3FFFFFFF, product_lo=0x00000001. Then M=-1, Q=-1 -> hi=0, lo=1.
- Start M=5, Q=3. Pulse start with M=9, Q=9 at cycle 4 -> ignored; result hi=0, lo=15. Start on the done cycle with M=2, Q=-4 -> accepted; result hi=0xFFFFFFFF, lo=0xFFFFFFF8.
- Start M=123, Q=456, assert clr at cycle 8 -> busy=0, done=0, products 0 immediately; no done pulse afterwards.
- MUL_EARLY_TERM_EN defined:
  - M=5, Q=3 -> done 3 cycles after start, lo=15.
  - Q=0 -> done after 1 cycle, product 0.
  - Q=-1 with M=6 -> done after 2 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
